// File: rtl/clock_set_ctrl.sv
// Clock mode/setting controller: RUN->SET_HOUR->SET_MIN sequencing, hold-to-repeat increments, idle timeout, blink blanking.
// All outputs registered, one cycle after the causing button edge or terminal tick; no backpressure, timing advances on tick only.
module clock_set_ctrl #(
    parameter int REPEAT_DLY = 500,
    parameter int REPEAT_PER = 100,
    parameter int TIMEOUT    = 6000,
    parameter int BLINK_HALF = 250
) (
    input  logic       clk,
    input  logic       sys_rst_n,
    input  logic       tick,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic       set_time,
    output logic       set_hour,
    output logic       set_min,
    output logic [1:0] mode,
    output logic       blank_hour,
    output logic       blank_min
);

    localparam int HW = ((REPEAT_DLY > REPEAT_PER) ? $clog2(REPEAT_DLY) : $clog2(REPEAT_PER)) + 1;
    localparam int IW = $clog2(TIMEOUT) + 1;
    localparam int BW = $clog2(BLINK_HALF) + 1;

    localparam logic [HW-1:0] DLY_LAST   = HW'(REPEAT_DLY - 1);
    localparam logic [HW-1:0] PER_LAST   = HW'(REPEAT_PER - 1);
    localparam logic [IW-1:0] IDLE_LAST  = IW'(TIMEOUT - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10,
        BAD      = 2'b11
    } state_t;

    state_t        state;
    state_t        nxt_state;
    logic          btn_mode_q;
    logic          btn_inc_q;
    logic          inc_armed;
    logic          rpt_on;
    logic          phase;
    logic [HW-1:0] hold_cnt;
    logic [IW-1:0] idle_cnt;
    logic [BW-1:0] blink_cnt;

    logic          rise_mode;
    logic          rise_inc;
    logic          in_set;
    logic          rpt_hit;
    logic          inc_evt;
    logic          timeout_hit;
    logic          restart;
    logic          pulse;
    logic [BW-1:0] nxt_blink_cnt;
    logic          nxt_phase;

    always_comb begin
        rise_mode   = btn_mode & ~btn_mode_q;
        rise_inc    = btn_inc & ~btn_inc_q;
        in_set      = (state == SET_HOUR) || (state == SET_MIN);
        rpt_hit     = in_set && inc_armed && btn_inc && tick &&
                      (hold_cnt >= (rpt_on ? PER_LAST : DLY_LAST));
        // A mode edge swallows a coincident increment; an increment counts as activity
        inc_evt     = in_set && !rise_mode && (rise_inc || rpt_hit);
        timeout_hit = in_set && tick && !inc_evt && (idle_cnt >= IDLE_LAST);

        nxt_state = state;
        case (state)
            RUN: begin
                if (rise_mode) nxt_state = SET_HOUR;
            end
            SET_HOUR: begin
                if (timeout_hit)    nxt_state = RUN;
                else if (rise_mode) nxt_state = SET_MIN;
            end
            SET_MIN: begin
                if (timeout_hit || rise_mode) nxt_state = RUN;
            end
            default: nxt_state = RUN;
        endcase

        restart = (nxt_state != state) || (nxt_state == RUN);
        pulse   = inc_evt && !restart;

        nxt_blink_cnt = blink_cnt;
        nxt_phase     = phase;
        if (restart || inc_evt) begin
            nxt_blink_cnt = '0;
            nxt_phase     = 1'b0;
        end else if (tick) begin
            if (blink_cnt >= BLINK_LAST) begin
                nxt_blink_cnt = '0;
                nxt_phase     = ~phase;
            end else begin
                nxt_blink_cnt = blink_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= RUN;
            btn_mode_q <= 1'b1;
            btn_inc_q  <= 1'b1;
            inc_armed  <= 1'b0;
            rpt_on     <= 1'b0;
            phase      <= 1'b0;
            hold_cnt   <= '0;
            idle_cnt   <= '0;
            blink_cnt  <= '0;
            set_time   <= 1'b0;
            set_hour   <= 1'b0;
            set_min    <= 1'b0;
            mode       <= 2'b00;
            blank_hour <= 1'b0;
            blank_min  <= 1'b0;
        end else begin
            btn_mode_q <= btn_mode;
            btn_inc_q  <= btn_inc;
            state      <= nxt_state;
            mode       <= nxt_state;
            set_time   <= (nxt_state == SET_HOUR) || (nxt_state == SET_MIN);
            set_hour   <= pulse && (state == SET_HOUR);
            set_min    <= pulse && (state == SET_MIN);
            blink_cnt  <= nxt_blink_cnt;
            phase      <= nxt_phase;
            blank_hour <= (nxt_state == SET_HOUR) && nxt_phase;
            blank_min  <= (nxt_state == SET_MIN) && nxt_phase;

            // Repeat only follows a press accepted in the current SET state
            if (restart || !btn_inc) begin
                inc_armed <= 1'b0;
                rpt_on    <= 1'b0;
                hold_cnt  <= '0;
            end else if (rise_inc) begin
                inc_armed <= 1'b1;
                rpt_on    <= 1'b0;
                hold_cnt  <= '0;
            end else if (rpt_hit) begin
                rpt_on    <= 1'b1;
                hold_cnt  <= '0;
            end else if (inc_armed && tick && (hold_cnt != '1)) begin
                hold_cnt  <= hold_cnt + 1'b1;
            end

            if (restart || rise_mode || inc_evt) begin
                idle_cnt <= '0;
            end else if (tick && (idle_cnt != '1)) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: expected pulses and mode changes are queued by the stimulus and matched by a negedge monitor.
module tb_clock_set_ctrl;

    logic       clk = 1'b0;
    logic       sys_rst_n;
    logic       tick;
    logic       btn_mode;
    logic       btn_inc;
    logic       set_time;
    logic       set_hour;
    logic       set_min;
    logic [1:0] mode;
    logic       blank_hour;
    logic       blank_min;

    typedef struct {
        int         cyc;
        logic [1:0] val;
    } ev_t;

    ev_t        pulse_q[$];
    ev_t        mode_q[$];
    int         cyc       = 0;
    int         checks    = 0;
    int         errors    = 0;
    logic [1:0] prev_mode = 2'b00;
    int         p;
    int         q;

    clock_set_ctrl dut (
        .clk        (clk),
        .sys_rst_n  (sys_rst_n),
        .tick       (tick),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .set_time   (set_time),
        .set_hour   (set_hour),
        .set_min    (set_min),
        .mode       (mode),
        .blank_hour (blank_hour),
        .blank_min  (blank_min)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic exp_pulse(input int c, input logic [1:0] v);
        ev_t e;
        e.cyc = c;
        e.val = v;
        pulse_q.push_back(e);
    endtask

    task automatic exp_mode(input int c, input logic [1:0] v);
        ev_t e;
        e.cyc = c;
        e.val = v;
        mode_q.push_back(e);
    endtask

    task automatic press_mode(input logic [1:0] m);
        btn_mode = 1'b1;
        exp_mode(cyc + 1, m);
        step(1);
        btn_mode = 1'b0;
        step(2);
    endtask

    task automatic press_inc(input logic [1:0] v);
        btn_inc = 1'b1;
        if (v != 2'b00) exp_pulse(cyc + 1, v);
        step(1);
        btn_inc = 1'b0;
        step(2);
    endtask

    always @(negedge clk) begin : monitor
        ev_t e;
        if (!sys_rst_n) begin
            prev_mode = mode;
        end else begin
            while (pulse_q.size() > 0 && pulse_q[0].cyc < cyc) begin
                e = pulse_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_pulse: saw none, expected {hour,min}=%b at cycle %0d", e.val, e.cyc);
            end
            while (mode_q.size() > 0 && mode_q[0].cyc < cyc) begin
                e = mode_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_mode: saw none, expected mode=%b at cycle %0d", e.val, e.cyc);
            end
            if (set_hour || set_min) begin
                checks++;
                if (pulse_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse at cycle %0d: got {hour,min}=%b, expected none", cyc, {set_hour, set_min});
                end else begin
                    e = pulse_q.pop_front();
                    if (e.cyc != cyc || e.val != {set_hour, set_min}) begin
                        errors++;
                        $display("FAIL pulse: got {hour,min}=%b at cycle %0d, expected %b at cycle %0d",
                                 {set_hour, set_min}, cyc, e.val, e.cyc);
                    end
                end
            end
            if (mode != prev_mode) begin
                checks++;
                if (mode_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_mode at cycle %0d: got mode=%b, expected no change from %b", cyc, mode, prev_mode);
                end else begin
                    e = mode_q.pop_front();
                    if (e.cyc != cyc || {set_time, mode} != {e.val != 2'b00, e.val}) begin
                        errors++;
                        $display("FAIL mode_change: got {set_time,mode}=%b at cycle %0d, expected %b at cycle %0d",
                                 {set_time, mode}, cyc, {e.val != 2'b00, e.val}, e.cyc);
                    end
                end
            end
            prev_mode = mode;
        end
    end

    initial begin
        sys_rst_n = 1'b0;
        tick      = 1'b1;
        btn_mode  = 1'b1;
        btn_inc   = 1'b1;
        step(3);
        chk("reset_outputs", {set_time, set_hour, set_min, mode, blank_hour, blank_min}, 0);

        // Both buttons held through reset release: no edges
        sys_rst_n = 1'b1;
        step(5);
        chk("held_mode_no_edge", mode, 0);
        btn_mode = 1'b0;
        step(2);
        press_mode(2'b01);
        step(600);
        btn_inc = 1'b0;
        step(2);
        press_mode(2'b10);
        press_mode(2'b00);
        chk("run_set_time", set_time, 0);

        press_inc(2'b00);
        step(5);

        // Blink phase and five single increments in SET_HOUR
        p = cyc;
        press_mode(2'b01);
        step(p + 250 - cyc);
        chk("blink_off_before_half", blank_hour, 0);
        step(1);
        chk("blink_on_after_half", {blank_hour, blank_min}, 2'b10);
        btn_inc = 1'b1;
        exp_pulse(cyc + 1, 2'b10);
        step(1);
        chk("blink_cleared_by_inc", blank_hour, 0);
        btn_inc = 1'b0;
        step(2);
        repeat (4) press_inc(2'b10);

        // Blink counter frozen while tick is low
        p = cyc - 3;
        tick = 1'b0;
        step(300);
        chk("tick_gated_blink", blank_hour, 0);
        tick = 1'b1;
        step(p + 550 - cyc);
        chk("gated_blink_before", blank_hour, 0);
        step(1);
        chk("gated_blink_after", blank_hour, 1);

        // Mode and increment rising together: mode wins
        btn_mode = 1'b1;
        btn_inc  = 1'b1;
        exp_mode(cyc + 1, 2'b10);
        step(1);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        step(2);

        // Auto-repeat in SET_MIN, held for 800 ticks
        p = cyc;
        btn_inc = 1'b1;
        exp_pulse(p + 1,   2'b01);
        exp_pulse(p + 501, 2'b01);
        exp_pulse(p + 601, 2'b01);
        exp_pulse(p + 701, 2'b01);
        exp_pulse(p + 801, 2'b01);
        step(801);
        btn_inc = 1'b0;
        step(300);
        chk("blank_min_phase", {blank_hour, blank_min}, 2'b01);
        press_mode(2'b00);
        chk("run_blank", {blank_hour, blank_min}, 0);

        // Idle timeout
        p = cyc;
        press_mode(2'b01);
        exp_mode(p + 6001, 2'b00);
        step(p + 6005 - cyc);

        // A press at tick 5000 restarts the idle window
        q = cyc;
        press_mode(2'b01);
        step(q + 5000 - cyc);
        btn_inc = 1'b1;
        exp_pulse(cyc + 1, 2'b10);
        step(1);
        btn_inc = 1'b0;
        step(q + 6001 - cyc);
        chk("no_timeout_after_press", {set_time, mode}, 3'b101);
        exp_mode(q + 11001, 2'b00);
        step(q + 11005 - cyc);

        // Reset in the middle of an auto-repeat
        press_mode(2'b01);
        press_mode(2'b10);
        p = cyc;
        btn_inc = 1'b1;
        exp_pulse(p + 1,   2'b01);
        exp_pulse(p + 501, 2'b01);
        step(550);
        chk("pre_reset_mode", {set_time, mode}, 3'b110);
        sys_rst_n = 1'b0;
        #1;
        chk("reset_mid_repeat", {set_time, set_hour, set_min, mode, blank_hour, blank_min}, 0);
        step(2);
        sys_rst_n = 1'b1;
        step(600);
        btn_inc = 1'b0;
        step(3);

        chk("pulse_queue_drained", pulse_q.size(), 0);
        chk("mode_queue_drained", mode_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
